// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone RAM arbiter.
package wb_arb_pkg;

  localparam int NUM_M = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int SW    = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [NUM_M-1:0] GNT_NONE = 2'b00;
  localparam logic [NUM_M-1:0] GNT_M0   = 2'b01;
  localparam logic [NUM_M-1:0] GNT_M1   = 2'b10;

  localparam logic [DW-1:0] DAT_DEFAULT = 32'h0;

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wb_req_t;

  function automatic logic [NUM_M-1:0] state_grant(input arb_state_e s);
    case (s)
      ARB_OWN0: state_grant = GNT_M0;
      ARB_OWN1: state_grant = GNT_M1;
      default:  state_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer hang detector: counts unacknowledged strobe edges and fires a
// single-cycle abort when the limit is reached.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic abort
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

  logic [TO_WIDTH-1:0] cnt;

  assign abort = (cnt == LIMIT);

  // abort clears the count itself, so the pulse is exactly one cycle wide
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cnt <= '0;
    else if (abort || !active || ack)  cnt <= '0;
    else if (cnt != LIMIT)             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of the OpenRAM
// wrapper; grant is held for the owner's whole cyc, with a hang watchdog.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [31:0]   m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [31:0]   m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [31:0]   m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [31:0]   m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [31:0]   s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic          s_ack_i,
  input  logic [31:0]   s_dat_i,
  output logic [1:0]    grant_o
);

  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state, state_nx;
  logic       last_r, last_nx;

  wb_req_t [NUM_M-1:0] mreq;
  wb_req_t             sel_req;
  logic    [NUM_M-1:0] req;
  logic    [NUM_M-1:0] gnt;
  logic                own_vld, own_idx;
  logic                abort;

  logic [NUM_M-1:0]         ack_v, err_v;
  logic [NUM_M-1:0][DW-1:0] rdat_v;

  assign mreq[0] = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign mreq[1] = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  always_comb begin
    for (int i = 0; i < NUM_M; i++) req[i] = mreq[i].cyc & mreq[i].stb;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ARB_IDLE;
      last_r <= 1'b1;
    end else begin
      state  <= state_nx;
      last_r <= last_nx;
    end
  end

  // ownership only moves through IDLE, which forces one dead cycle between owners
  always_comb begin
    state_nx = state;
    last_nx  = last_r;
    case (state)
      ARB_IDLE: begin
        if (req[0] && req[1]) state_nx = last_r ? ARB_OWN0 : ARB_OWN1;
        else if (req[0])      state_nx = ARB_OWN0;
        else if (req[1])      state_nx = ARB_OWN1;
      end
      ARB_OWN0: if (!m0_cyc_i) begin
        state_nx = ARB_IDLE;
        last_nx  = 1'b0;
      end
      ARB_OWN1: if (!m1_cyc_i) begin
        state_nx = ARB_IDLE;
        last_nx  = 1'b1;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  assign gnt     = state_grant(state);
  assign grant_o = gnt;
  assign own_vld = (state != ARB_IDLE);
  assign own_idx = (state == ARB_OWN1);
  assign sel_req = own_vld ? mreq[own_idx] : '0;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_wdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .active (own_vld & sel_req.cyc & sel_req.stb),
    .ack    (s_ack_i),
    .abort  (abort)
  );

  // slave side depends only on state, abort and master inputs, never on s_ack_i
  assign s_cyc_o = sel_req.cyc;
  assign s_stb_o = sel_req.stb & ~abort;
  assign s_we_o  = sel_req.we;
  assign s_sel_o = sel_req.sel;
  assign s_adr_o = sel_req.adr;
  assign s_dat_o = sel_req.dat;

  always_comb begin
    ack_v  = '0;
    err_v  = '0;
    rdat_v = {NUM_M{DAT_DEFAULT}};
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt[i]) begin
        ack_v[i]  = s_ack_i & mreq[i].stb & ~abort;
        err_v[i]  = abort;
        rdat_v[i] = s_dat_i;
      end
    end
  end

  assign m0_ack_o = ack_v[0];
  assign m0_err_o = err_v[0];
  assign m0_dat_o = rdat_v[0];
  assign m1_ack_o = ack_v[1];
  assign m1_err_o = err_v[1];
  assign m1_dat_o = rdat_v[1];

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed arbitration/timeout scenarios plus random
// traffic, all outputs compared each cycle against a behavioural model.
module tb_wb_ram_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        cyc = '0, stb = '0, we = '0;
  logic [1:0][3:0]   sel = '0;
  logic [1:0][31:0]  adr = '0, wdat = '0;
  logic              s_ack = 1'b0;
  logic [31:0]       s_rdat = '0;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [1:0]  grant;

  wb_ram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .m0_cyc_i (cyc[0]),   .m0_stb_i (stb[0]),  .m0_we_i (we[0]),
    .m0_sel_i (sel[0]),   .m0_adr_i (adr[0]),  .m0_dat_i (wdat[0]),
    .m0_ack_o (m0_ack),   .m0_err_o (m0_err),  .m0_dat_o (m0_rdat),
    .m1_cyc_i (cyc[1]),   .m1_stb_i (stb[1]),  .m1_we_i (we[1]),
    .m1_sel_i (sel[1]),   .m1_adr_i (adr[1]),  .m1_dat_i (wdat[1]),
    .m1_ack_o (m1_ack),   .m1_err_o (m1_err),  .m1_dat_o (m1_rdat),
    .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),   .s_we_o  (s_we),
    .s_sel_o  (s_sel),    .s_adr_o  (s_adr),   .s_dat_o (s_wdat),
    .s_ack_i  (s_ack),    .s_dat_i  (s_rdat),
    .grant_o  (grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference: owner (-1 = nobody), last served master, unacked wait edges
  int own  = -1;
  int last = 1;
  int wd   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit aborting();
    return (own >= 0) && (wd == TO);
  endfunction

  task automatic model_reset();
    own = -1; last = 1; wd = 0;
  endtask

  task automatic model_edge();
    bit r0, r1;
    if (rst) begin
      model_reset();
      return;
    end
    r0 = cyc[0] && stb[0];
    r1 = cyc[1] && stb[1];
    if (own < 0) begin
      wd = 0;
      if (r0 && r1) own = (last == 0) ? 1 : 0;
      else if (r0)  own = 0;
      else if (r1)  own = 1;
    end else begin
      if (aborting() || !(cyc[own] && stb[own]) || s_ack) wd = 0;
      else if (wd < TO) wd++;
      if (!cyc[own]) begin
        last = own;
        own  = -1;
      end
    end
  endtask

  task automatic compare_all();
    bit               ab = aborting();
    logic [1:0]       e_gnt = '0, e_ack = '0, e_err = '0;
    logic [1:0][31:0] e_rd  = '0;
    logic [6:0]       e_ctl = '0;
    logic [31:0]      e_adr = '0, e_dat = '0;
    if (own >= 0) begin
      e_gnt[own] = 1'b1;
      e_ack[own] = s_ack & stb[own] & !ab;
      e_err[own] = ab;
      e_rd[own]  = s_rdat;
      e_ctl      = {cyc[own], stb[own] & !ab, we[own], sel[own]};
      e_adr      = adr[own];
      e_dat      = wdat[own];
    end
    chk("grant",  grant, e_gnt);
    chk("s_ctl",  {s_cyc, s_stb, s_we, s_sel}, e_ctl);
    chk("s_adr",  s_adr, e_adr);
    chk("s_dat",  s_wdat, e_dat);
    chk("m_ack",  {m1_ack, m0_ack}, e_ack);
    chk("m_err",  {m1_err, m0_err}, e_err);
    chk("m0_dat", m0_rdat, e_rd[0]);
    chk("m1_dat", m1_rdat, e_rd[1]);
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w,
                       input logic [3:0] bs, input logic [31:0] a, input logic [31:0] d);
    cyc[i] = c; stb[i] = s; we[i] = w; sel[i] = bs; adr[i] = a; wdat[i] = d;
  endtask

  task automatic clear_inputs();
    set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    s_ack = 1'b0;
  endtask

  // asserted mid-cycle: outputs must drop before the next edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // single m0 write
    clear_inputs();
    set_m(0, 1, 1, 1, 4'hF, 32'h30c0_0004, 32'hA5A5_0001);
    settle(); chk("wr_idle_stb", s_stb, 1'b0); tick();
    settle();
    chk("wr_grant", grant, 2'b01);
    chk("wr_adr", s_adr, 32'h30c0_0004);
    chk("wr_dat", s_wdat, 32'hA5A5_0001);
    chk("wr_sel", {s_we, s_sel}, 5'h1F);
    tick();
    s_ack = 1'b1;
    settle(); chk("wr_m0_ack", m0_ack, 1'b1); chk("wr_m1_ack", m1_ack, 1'b0); tick();
    clear_inputs();
    settle(); tick();
    settle(); chk("wr_release", grant, 2'b00); tick();

    // simultaneous requests from reset: 01, idle, 10, idle, 01
    do_reset();
    clear_inputs();
    set_m(0, 1, 1, 0, 4'hF, 32'h30c0_0010, 32'h0);
    set_m(1, 1, 1, 0, 4'hF, 32'h30c0_0020, 32'h0);
    settle(); tick();
    cyc[0] = 0; stb[0] = 0;
    settle(); chk("tie_g1", grant, 2'b01); tick();
    cyc[0] = 1; stb[0] = 1;
    settle(); chk("tie_gap1", grant, 2'b00); tick();
    cyc[1] = 0; stb[1] = 0;
    settle(); chk("tie_g2", grant, 2'b10); tick();
    cyc[1] = 1; stb[1] = 1;
    settle(); chk("tie_gap2", grant, 2'b00); tick();
    settle(); chk("tie_g3", grant, 2'b01); tick();

    // m1 holds cyc over several reads with stb gaps while m0 waits
    do_reset();
    clear_inputs();
    set_m(1, 1, 1, 0, 4'hF, 32'h30c0_0100, 32'h0);
    settle(); tick();
    set_m(0, 1, 1, 1, 4'hF, 32'h30c0_0200, 32'h1234);
    for (int k = 0; k < 9; k++) begin
      stb[1] = (k % 3 != 1);
      adr[1] = 32'h30c0_0100 + 32'(4 * k);
      s_ack  = stb[1];
      s_rdat = 32'hD000_0000 + 32'(k);
      settle();
      chk("hold_grant", grant, 2'b10);
      chk("hold_adr", s_adr, 32'h30c0_0100 + 32'(4 * k));
      chk("hold_m0_ack", m0_ack, 1'b0);
      tick();
    end
    cyc[1] = 0; stb[1] = 0; s_ack = 0;
    settle(); chk("hold_last", grant, 2'b10); tick();
    settle(); chk("hold_gap", grant, 2'b00); tick();
    settle(); chk("hold_m0", grant, 2'b01); tick();

    // slave never acks: single err pulse at the 16th waiting edge
    do_reset();
    clear_inputs();
    set_m(0, 1, 1, 0, 4'hF, 32'h30c0_0008, 32'h0);
    settle(); tick();
    for (int n = 1; n <= TO; n++) begin
      settle(); chk("to_no_err", m0_err, 1'b0); tick();
    end
    s_ack = 1'b1;
    settle();
    chk("to_err", m0_err, 1'b1);
    chk("to_ack_masked", m0_ack, 1'b0);
    chk("to_stb_low", s_stb, 1'b0);
    tick();
    s_ack = 1'b0;
    settle(); chk("to_err_clear", m0_err, 1'b0); chk("to_stb_back", s_stb, 1'b1); tick();
    clear_inputs();
    settle(); tick();
    s_ack = 1'b1;
    settle(); chk("idle_spur_ack", {m1_ack, m0_ack}, 2'b00); tick();
    s_ack = 1'b0;

    // random traffic, alternating normal and hung-slave phases
    for (int c = 0; c < 4000; c++) begin
      bit hang = ((c / 500) % 2) == 1;
      if ($urandom_range(299, 0) == 0) do_reset();
      for (int i = 0; i < 2; i++) begin
        if (cyc[i]) begin
          if ($urandom_range(hang ? 39 : 9, 0) == 0) cyc[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) cyc[i] = 1'b1;
        stb[i]  = cyc[i] && (hang || $urandom_range(3, 0) != 0);
        we[i]   = 1'($urandom);
        sel[i]  = 4'($urandom);
        adr[i]  = $urandom;
        wdat[i] = $urandom;
      end
      s_ack  = hang ? 1'b0 : ($urandom_range(2, 0) == 0);
      s_rdat = $urandom;
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
